// File: rtl/dec_hazard_stage.sv
// Decode stage: IF/ID holding register with valid/ready flow control, register file,
// EX/MEM/WB operand forwarding, load-use / no-forward interlock and branch flush.
module dec_hazard_stage #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rstn,

   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      if_inst,
   output logic             id_ready,
   input  logic             flush,

   input  logic             ctl_use1,
   input  logic             ctl_use2,
   input  logic [AW-1:0]    ctl_wa,
   input  logic             ctl_we,

   input  logic             ex_we,
   input  logic             ex_is_load,
   input  logic [AW-1:0]    ex_wa,
   input  logic [XLEN-1:0]  ex_data,

   input  logic             mem_we,
   input  logic [AW-1:0]    mem_wa,
   input  logic [XLEN-1:0]  mem_data,

   input  logic             wb_we,
   input  logic [AW-1:0]    wb_wa,
   input  logic [XLEN-1:0]  wb_data,

   input  logic             ex_ready,

   output logic             id_valid,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic [XLEN-1:0]  id_rd1,
   output logic [XLEN-1:0]  id_rd2,
   output logic [AW-1:0]    id_wa,
   output logic             id_we,
   output logic             hazard,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             vld;
   logic [31:0]      pc_q;
   logic [31:0]      inst_q;
   logic [XLEN-1:0]  rf [NREG];

   logic [AW-1:0]    rs_idx;
   logic [AW-1:0]    rt_idx;
   logic             haz1;
   logic             haz2;
   logic             advance;

   // Source priority: r0, EX, MEM (forwarding builds only), WB bypass, register file.
   function automatic logic [XLEN-1:0] resolve(
      input logic [AW-1:0]   s,
      input logic [XLEN-1:0] rf_val,
      input logic            e_we,
      input logic [AW-1:0]   e_wa,
      input logic [XLEN-1:0] e_data,
      input logic            m_we,
      input logic [AW-1:0]   m_wa,
      input logic [XLEN-1:0] m_data,
      input logic            w_we,
      input logic [AW-1:0]   w_wa,
      input logic [XLEN-1:0] w_data
   );
      if (s == '0)
         return '0;
      if (FWD_EN != 0 && e_we && e_wa == s)
         return e_data;
      if (FWD_EN != 0 && m_we && m_wa == s)
         return m_data;
      if (w_we && w_wa == s)
         return w_data;
      return rf_val;
   endfunction

   function automatic logic src_hazard(
      input logic          used,
      input logic [AW-1:0] s,
      input logic          e_we,
      input logic          e_ld,
      input logic [AW-1:0] e_wa,
      input logic          m_we,
      input logic [AW-1:0] m_wa
   );
      if (!used || s == '0)
         return 1'b0;
      if (FWD_EN != 0)
         return e_we && e_ld && (e_wa == s);
      return (e_we && e_wa == s) || (m_we && m_wa == s);
   endfunction

   assign rs_idx = inst_q[21 +: AW];
   assign rt_idx = inst_q[16 +: AW];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else if (wb_we && wb_wa != '0) begin
         rf[wb_wa] <= wb_data;
      end
   end

   always_comb begin
      id_rd1 = resolve(rs_idx, rf[rs_idx], ex_we, ex_wa, ex_data,
                       mem_we, mem_wa, mem_data, wb_we, wb_wa, wb_data);
      id_rd2 = resolve(rt_idx, rf[rt_idx], ex_we, ex_wa, ex_data,
                       mem_we, mem_wa, mem_data, wb_we, wb_wa, wb_data);
      haz1   = src_hazard(ctl_use1, rs_idx, ex_we, ex_is_load, ex_wa, mem_we, mem_wa);
      haz2   = src_hazard(ctl_use2, rt_idx, ex_we, ex_is_load, ex_wa, mem_we, mem_wa);
   end

   assign hazard   = vld && (haz1 || haz2);
   assign id_valid = vld && !hazard && !flush;
   assign advance  = !vld || (ex_ready && id_valid);
   assign id_ready = advance || flush;

   assign id_pc   = pc_q;
   assign id_inst = inst_q;
   assign id_wa   = ctl_wa;
   assign id_we   = ctl_we && (ctl_wa != '0);

   // Flush beats everything, including a same-cycle fetch offer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld    <= 1'b0;
         pc_q   <= '0;
         inst_q <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (advance) begin
         vld <= if_valid;
         if (if_valid) begin
            pc_q   <= if_pc;
            inst_q <= if_inst;
         end
      end
   end

   // A killed instruction's stall is not counted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         stall_cnt <= '0;
      else if (hazard && !flush && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_dec_hazard_stage.sv
// Directed bench for dec_hazard_stage: a forwarding build (u0) and a no-forward,
// 2-bit-counter build (u1) share one stimulus; expectations go through a scoreboard queue.
module tb_dec_hazard_stage;

   logic        clk;
   logic        rstn;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        flush;
   logic        ctl_use1;
   logic        ctl_use2;
   logic [4:0]  ctl_wa;
   logic        ctl_we;
   logic        ex_we;
   logic        ex_is_load;
   logic [4:0]  ex_wa;
   logic [31:0] ex_data;
   logic        mem_we;
   logic [4:0]  mem_wa;
   logic [31:0] mem_data;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_data;
   logic        ex_ready;

   logic        u0_id_ready, u0_id_valid, u0_id_we, u0_hazard;
   logic [31:0] u0_id_pc, u0_id_inst, u0_id_rd1, u0_id_rd2;
   logic [4:0]  u0_id_wa;
   logic [15:0] u0_stall_cnt;

   logic        u1_id_ready, u1_id_valid, u1_id_we, u1_hazard;
   logic [31:0] u1_id_pc, u1_id_inst, u1_id_rd1, u1_id_rd2;
   logic [4:0]  u1_id_wa;
   logic [1:0]  u1_stall_cnt;

   dec_hazard_stage u0 (
      .clk(clk), .rstn(rstn),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(u0_id_ready),
      .flush(flush), .ctl_use1(ctl_use1), .ctl_use2(ctl_use2), .ctl_wa(ctl_wa), .ctl_we(ctl_we),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_data(ex_data),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_data(mem_data),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_data(wb_data), .ex_ready(ex_ready),
      .id_valid(u0_id_valid), .id_pc(u0_id_pc), .id_inst(u0_id_inst),
      .id_rd1(u0_id_rd1), .id_rd2(u0_id_rd2), .id_wa(u0_id_wa), .id_we(u0_id_we),
      .hazard(u0_hazard), .stall_cnt(u0_stall_cnt)
   );

   dec_hazard_stage #(.FWD_EN(0), .CNT_W(2)) u1 (
      .clk(clk), .rstn(rstn),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(u1_id_ready),
      .flush(flush), .ctl_use1(ctl_use1), .ctl_use2(ctl_use2), .ctl_wa(ctl_wa), .ctl_we(ctl_we),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_data(ex_data),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_data(mem_data),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_data(wb_data), .ex_ready(ex_ready),
      .id_valid(u1_id_valid), .id_pc(u1_id_pc), .id_inst(u1_id_inst),
      .id_rd1(u1_id_rd1), .id_rd2(u1_id_rd2), .id_wa(u1_id_wa), .id_we(u1_id_we),
      .hazard(u1_hazard), .stall_cnt(u1_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   int          n_pass  = 0;
   int          n_total = 0;
   logic [63:0] exp_q[$];
   string       tag_q[$];

   task automatic push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [63:0] obs);
      logic [63:0] e;
      string       t;
      n_total++;
      if (exp_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) n_pass++;
         else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
      return {6'd0, rs, rt, 16'h0};
   endfunction

   task automatic clear_prod();
      ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_data = 0;
      mem_we = 0; mem_wa = 0; mem_data = 0;
      wb_we = 0; wb_wa = 0; wb_data = 0;
   endtask

   task automatic load(input logic [31:0] pc, input logic [31:0] inst,
                       input logic u1s, input logic u2s);
      clear_prod();
      flush = 0; if_valid = 1; if_pc = pc; if_inst = inst;
      ctl_use1 = u1s; ctl_use2 = u2s; ex_ready = 1;
      tick();
      if_valid = 0; ex_ready = 0;
   endtask

   task automatic pulse_reset();
      rstn = 0;
      #2;
      rstn = 1;
   endtask

   initial begin
      rstn = 0; if_valid = 0; if_pc = 0; if_inst = 0; flush = 0;
      ctl_use1 = 0; ctl_use2 = 0; ctl_wa = 0; ctl_we = 0; ex_ready = 1;
      clear_prod();

      // reset state
      #2;
      push("rst_ready", 1); push("rst_valid", 0); push("rst_cnt", 0);
      push("rst_pc", 0); push("rst_inst", 0);
      chk(u0_id_ready); chk(u0_id_valid); chk(u0_stall_cnt); chk(u0_id_pc); chk(u0_id_inst);
      tick();
      rstn = 1;
      tick();

      // r5 = 0x1234, then an attempted r0 write
      wb_we = 1; wb_wa = 5; wb_data = 32'h1234;
      tick();
      wb_wa = 0; wb_data = 32'hFFFF;
      tick();
      clear_prod();

      // basic flow, one-cycle latency
      load(32'h100, mk(5, 0), 1, 1);
      ctl_wa = 0; ctl_we = 1;
      push("basic_valid", 1); push("basic_rd1", 32'h1234); push("basic_rd2", 0);
      push("basic_pc", 32'h100); push("basic_hazard", 0); push("basic_ready", 0);
      push("wa0_we", 0);
      settle();
      chk(u0_id_valid); chk(u0_id_rd1); chk(u0_id_rd2); chk(u0_id_pc); chk(u0_hazard);
      chk(u0_id_ready); chk(u0_id_we);
      ctl_wa = 9;
      push("wa9_we", 1); push("wa9_wa", 9);
      #1;
      chk(u0_id_we); chk(u0_id_wa);
      ctl_we = 0;

      // backpressure: new offers ignored while ex_ready is low
      if_valid = 1; if_pc = 32'h200; if_inst = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         push("bp_pc", 32'h100); push("bp_inst", mk(5, 0));
         settle();
         chk(u0_id_pc); chk(u0_id_inst);
      end
      if_valid = 0;

      // r0 stays zero, even against a same-cycle WB to r0
      load(32'h104, mk(0, 0), 1, 1);
      wb_we = 1; wb_wa = 0; wb_data = 32'hFFFF;
      push("r0_bypass_rd1", 0); push("r0_bypass_rd2", 0);
      settle();
      chk(u0_id_rd1); chk(u0_id_rd2);
      tick();
      wb_we = 0;
      push("r0_rf_rd1", 0);
      settle();
      chk(u0_id_rd1);

      // EX forwarding and EX-over-MEM priority
      load(32'h108, mk(3, 7), 1, 0);
      ex_we = 1; ex_wa = 3; ex_data = 32'hAA;
      push("exfwd_rd1", 32'hAA); push("exfwd_hazard", 0); push("exfwd_valid", 1);
      settle();
      chk(u0_id_rd1); chk(u0_hazard); chk(u0_id_valid);
      tick();
      mem_we = 1; mem_wa = 3; mem_data = 32'hBB;
      push("ex_over_mem", 32'hAA);
      settle();
      chk(u0_id_rd1);
      tick();
      ex_we = 0;
      push("memfwd_rd1", 32'hBB);
      settle();
      chk(u0_id_rd1);
      tick();

      // load-use: unused source first, then the real interlock
      load(32'h10C, mk(0, 7), 0, 1);
      ctl_use2 = 0;
      ex_we = 1; ex_is_load = 1; ex_wa = 7; ex_data = 32'h99;
      push("unused_hazard", 0); push("unused_valid", 1);
      settle();
      chk(u0_hazard); chk(u0_id_valid);
      tick();
      ctl_use2 = 1; ex_ready = 1;
      push("lu_hazard", 1); push("lu_valid", 0); push("lu_ready", 0); push("lu_cnt_pre", 0);
      settle();
      chk(u0_hazard); chk(u0_id_valid); chk(u0_id_ready); chk(u0_stall_cnt);
      tick();
      ex_we = 0; ex_is_load = 0; ex_ready = 0;
      mem_we = 1; mem_wa = 7; mem_data = 32'h55;
      push("lu_cnt", 1); push("lu_res_hazard", 0); push("lu_res_valid", 1); push("lu_res_rd2", 32'h55);
      settle();
      chk(u0_stall_cnt); chk(u0_hazard); chk(u0_id_valid); chk(u0_id_rd2);
      tick();

      // flush together with a hazard, plus a discarded fetch offer
      mem_we = 0;
      ex_we = 1; ex_is_load = 1; ex_wa = 7;
      flush = 1; if_valid = 1; if_pc = 32'h300; if_inst = mk(1, 1);
      push("fl_hazard", 1); push("fl_valid", 0); push("fl_ready", 1);
      settle();
      chk(u0_hazard); chk(u0_id_valid); chk(u0_id_ready);
      tick();
      flush = 0; if_valid = 0;
      clear_prod();
      push("fl_after_valid", 0); push("fl_after_cnt", 1); push("fl_after_ready", 1);
      push("fl_after_pc", 32'h10C);
      settle();
      chk(u0_id_valid); chk(u0_stall_cnt); chk(u0_id_ready); chk(u0_id_pc);
      tick();

      // back-to-back throughput
      ctl_use1 = 0; ctl_use2 = 0; ex_ready = 1;
      for (int i = 0; i < 3; i++) begin
         if_valid = 1; if_pc = 32'h500 + 32'(4 * i); if_inst = mk(5'(i + 1), 0);
         tick();
         push("tp_valid", 1); push("tp_pc", 32'h500 + 32'(4 * i)); push("tp_ready", 1);
         settle();
         chk(u0_id_valid); chk(u0_id_pc); chk(u0_id_ready);
      end
      if_valid = 0;
      tick();
      push("tp_drain_valid", 0);
      settle();
      chk(u0_id_valid);

      // asynchronous reset mid-operation clears vld and the register file
      load(32'h600, mk(5, 0), 1, 0);
      push("pre_rst_rd1", 32'h1234);
      settle();
      chk(u0_id_rd1);
      rstn = 0;
      #1;
      push("mid_rst_valid", 0); push("mid_rst_ready", 1); push("mid_rst_ready_u1", 1);
      chk(u0_id_valid); chk(u0_id_ready); chk(u1_id_ready);
      tick();
      rstn = 1;
      load(32'h604, mk(5, 0), 1, 0);
      push("rf_cleared_u0", 0); push("rf_cleared_u1", 0);
      settle();
      chk(u0_id_rd1); chk(u1_id_rd1);
      tick();

      // no-forward build: ALU result stalls through EX and MEM, then WB bypass
      load(32'h700, mk(4, 0), 1, 0);
      ex_we = 1; ex_wa = 4; ex_data = 32'h11;
      push("nf_ex_hazard", 1); push("nf_ex_valid", 0); push("fw_ex_rd1", 32'h11);
      settle();
      chk(u1_hazard); chk(u1_id_valid); chk(u0_id_rd1);
      tick();
      ex_we = 0; mem_we = 1; mem_wa = 4; mem_data = 32'h22;
      push("nf_mem_hazard", 1); push("nf_mem_cnt", 1); push("fw_mem_rd1", 32'h22);
      settle();
      chk(u1_hazard); chk(u1_stall_cnt); chk(u0_id_rd1);
      tick();
      mem_we = 0; wb_we = 1; wb_wa = 4; wb_data = 32'h4444;
      push("nf_wb_hazard", 0); push("nf_wb_valid", 1); push("nf_wb_rd1", 32'h4444);
      push("nf_wb_cnt", 2);
      settle();
      chk(u1_hazard); chk(u1_id_valid); chk(u1_id_rd1); chk(u1_stall_cnt);
      tick();
      clear_prod();

      // 2-bit counter saturation over 5 hazard cycles
      pulse_reset();
      load(32'h800, mk(4, 0), 1, 0);
      ex_we = 1; ex_wa = 4;
      for (int i = 0; i < 5; i++) begin
         tick();
         push("sat_cnt", (i + 1 > 3) ? 3 : i + 1);
         settle();
         chk(u1_stall_cnt);
      end
      clear_prod();

      n_total++;
      assert (exp_q.size() == 0) n_pass++;
      else $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dec_hazard_stage.md
# dec_hazard_stage

Parametrised instruction-decode stage for the five-stage pipeline: an IF/ID register with valid/ready flow control, an integrated register file, operand forwarding from EX/MEM/WB, load-use interlock and branch flush. It sits between fetch and execute. It generalises the fixed 32x32 decode stage with configurable width, register count and forwarding mode, downstream backpressure, and a stall performance counter.

## Interface
- XLEN, 32: datapath and register width.
- NREG, 32: number of architectural registers, a power of two; AW = log2(NREG).
- FWD_EN, 1: 1 = full forwarding; 0 = no EX/MEM forwarding, stall until writeback.
- CNT_W, 16: width of the stall counter.

- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- if_valid / if_pc / if_inst  in  1/32/32  fetched instruction offer.
- id_ready  out  1  stage can accept from fetch this cycle.
- flush  in  1  branch/jump redirect; kill the held instruction.
- ctl_use1 / ctl_use2  in  1/1  held instruction reads rs / rt (from the control unit, decoded from id_inst).
- ctl_wa / ctl_we  in  AW/1  held instruction's destination and write enable.
- ex_we, ex_is_load, ex_wa, ex_data  in  1,1,AW,XLEN  EX-stage producer.
- mem_we, mem_wa, mem_data  in  1,AW,XLEN  MEM producer (mem_data is the load data or the ALU result).
- wb_we, wb_wa, wb_data  in  1,AW,XLEN  writeback port.
- ex_ready  in  1  execute accepts this cycle.
- id_valid  out  1  decoded bundle valid (gated by hazard).
- id_pc, id_inst  out  32  held PC and instruction.
- id_rd1, id_rd2  out  XLEN  resolved operands for inst[25:21] and inst[20:16] (low AW bits).
- id_wa, id_we  out  AW/1  passthrough of ctl_wa/ctl_we, with id_we forced 0 when wa = 0.
- hazard  out  1  stall condition active on a valid instruction.
- stall_cnt  out  CNT_W  saturating count of hazard cycles.

## Operation
- Holding register: vld, pc, inst. Reset: vld = 0, pc = 0, inst = 0, stall_cnt = 0, all registers = 0.
- Register file: NREG x XLEN. Written on the clock edge when wb_we and wb_wa != 0. Register 0 always reads 0.
- Operand resolution for source index s (rs or rt), first match wins:
  1. s = 0 -> 0.
  2. ex_we and ex_wa = s -> ex_data (FWD_EN = 1).
  3. mem_we and mem_wa = s -> mem_data (FWD_EN = 1).
  4. wb_we and wb_wa = s -> wb_data (write-before-read bypass, in both modes).
  5. Otherwise, the register file.
- Hazard, for each used source s != 0:
  - FWD_EN = 1: ex_we and ex_is_load and ex_wa = s.
  - FWD_EN = 0: (ex_we and ex_wa = s) or (mem_we and mem_wa = s).
- hazard = vld and (hazard1 or hazard2). Unused sources never stall.
- id_valid = vld and !hazard and !flush.
- advance = !vld or (ex_ready and id_valid).
- id_ready = advance or flush.
- Next state:
  - flush: vld <= 0. The if_valid offer in the same cycle is discarded. Highest priority.
  - Else if advance: vld <= if_valid, and pc/inst are loaded when if_valid is high.
  - Else: hold everything.
- stall_cnt increments each cycle hazard = 1 and saturates at 2^CNT_W - 1.

## Timing
- Latency: an instruction accepted at edge N appears with id_valid high after edge N (one cycle), provided there is no hazard.
- Throughput is one instruction per cycle with no hazards and ex_ready held high.
- Load-use costs exactly one bubble with FWD_EN = 1: the next cycle the load is in MEM and forwarding resolves.
- With FWD_EN = 0, a dependent instruction stalls up to 2 cycles; its data then comes through the WB bypass.
- All outputs are combinational from the held state and the producer inputs. There is no registered output path.
- Reset mid-operation: vld drops immediately (asynchronous), the register file clears, and id_ready = 1.
- Flush together with a hazard: flush wins and the stall counter does not increment in the flush cycle (hazard is still reported).

## Test plan
- Basic flow: write r5 = 0x1234 via WB. Offer an inst reading rs = 5 -> after 1 cycle, id_valid = 1 and id_rd1 = 0x1234.
- EX forwarding: ex_we = 1, ex_wa = 3, ex_data = 0xAA, not a load; held inst reads r3 -> id_rd1 = 0xAA, hazard = 0.
  - Same with mem_wa = 3, mem_data = 0xBB also present -> EX wins, 0xAA.
- Load-use: ex_is_load = 1, ex_wa = 7; inst uses rt = 7 -> hazard = 1, id_valid = 0, id_ready = 0, stall_cnt = 1.
  - Next cycle, with mem_wa = 7 and mem_data = 0x55 -> id_rd2 = 0x55, id_valid = 1.
- FWD_EN = 0 build: ex_wa = 4 (ALU op) -> 2 stall cycles; then a WB-bypassed value appears and stall_cnt = 2.
- Flush: vld = 1 with flush = 1 and if_valid = 1 -> next cycle id_valid = 0 and the offered inst is dropped.
  - Backpressure: ex_ready = 0 holds pc/inst stable for 3 cycles.
- r0 / saturation: wb_wa = 0 with wb_we = 1 -> r0 still reads 0.
  - CNT_W = 2 with 5 hazard cycles -> stall_cnt = 3.
